bus_arbiter_2to1: RTL and testbench
===================================

Name: bus_arbiter_2to1

Overview:
- Round-robin arbiter that shares one WIDTH-bit datapath port between two requesters, e.g. two sources competing for the register-file write-data bus or the memory write-data bus in the MIPS datapath.
- Owns the select line of a 2:1 WIDTH-bit mux and issues grants.
- Bounds how long one requester can hold the port while the other is waiting.
- Sits between the requesting units and the shared port. Output data is combinational through the mux; control outputs are registered.

Parameters:
WIDTH, 32, data width of each requester bus and of bus_out
MAX_HOLD, 4, maximum consecutive granted cycles while the other requester is waiting (must be >= 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req0  input  1  requester 0 wants the port; held high while it needs the port
req1  input  1  requester 1 wants the port
data0  input  WIDTH  requester 0 data (mux input I0)
data1  input  WIDTH  requester 1 data (mux input I1)
gnt0  output  1  registered grant to requester 0
gnt1  output  1  registered grant to requester 1
sel  output  1  registered mux select: 0 selects data0, 1 selects data1
bus_out  output  WIDTH  combinational: sel ? data1 : data0
bus_valid  output  1  gnt0 | gnt1

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: state=IDLE, gnt0=0, gnt1=0, sel=0, bus_valid=0, last=1 (so req0 wins the first tie), hold_cnt=0. bus_out=data0 through the mux.
- Reset asserted mid-grant: grants drop immediately (asynchronously). After reset is released, arbitration restarts from IDLE with last=1.
- Grant rules:
  - gnt0 and gnt1 are never high together.
  - sel always equals the granted index.
  - In IDLE, sel keeps its last value.
- States:
  - IDLE: no grant.
  - G0: gnt0=1, sel=0.
  - G1: gnt1=1, sel=1.
- Latency: a request sampled high at edge N gives a grant visible after edge N, i.e. 1 cycle.
- IDLE transitions:
  - req0&req1: grant the index != last.
  - req0 only: go to G0.
  - req1 only: go to G1.
  - Neither: stay in IDLE.
- hold_cnt:
  - Loads 1 on entry to a grant state.
  - Increments on each cycle the grant stays in place.
  - Saturates at MAX_HOLD.
- G0 transitions, evaluated at each edge (G1 is symmetric):
  - req0=0 and req1=1: go directly to G1 with no idle bubble.
  - req0=0 and req1=0: go to IDLE.
  - req0=1, req1=1 and hold_cnt==MAX_HOLD: forced switch to G1.
  - Otherwise: stay in G0. With req1=0 the grant is held indefinitely and hold_cnt stays saturated.
- last: updated to the granted index on every grant entry.
- Worst-case wait for a waiting requester: MAX_HOLD+1 cycles from its request to its grant.
- Simultaneous events:
  - A requester dropping req on the same edge hold_cnt hits MAX_HOLD: treated as a release, not a forced switch. The result is the same next state.
  - A request arriving on the same edge as a release: it is seen by that release's transition.
- Width: bus_out is a pure WIDTH-bit mux with no truncation or extension. data changes propagate to bus_out in the same cycle.

Test Plan:
- Reset then idle: hold reset 2 cycles with all reqs 0, release. Expect gnt0=gnt1=0, sel=0, bus_valid=0, bus_out=data0=35.
- Single requester, MAX_HOLD=4: data1=32, req1 high for 6 cycles. Expect gnt1=1 one cycle after req1 rises, held all 6 cycles with bus_out=32, then IDLE one cycle after req1 drops, with sel staying 1.
- Tie after reset: req0=req1=1 on the same edge, data0=35, data1=64. Expect G0 first; after 4 grant cycles a forced switch to G1 with bus_out=64; 4 cycles later back to G0 with bus_out=35.
- Handoff with no bubble: G0 active, req1 already high, req0 drops at hold_cnt=2. Expect gnt1=1 on the very next cycle and bus_valid never 0.
- Mid-grant reset: reset pulsed while in G1. Expect gnt1=0 and sel=0 before the next clock edge. With req0=req1=1 after release, expect G0 first.
- Round-robin fairness: req0 and req1 toggled in alternating single-cycle releases for 20 cycles. Expect grant counts to differ by at most 1 and gnt0&gnt1 never both 1.

Source files
------------

// File: rtl/bus_arbiter_2to1.sv
// Two-requester round-robin arbiter driving the select of a shared WIDTH-bit mux.
// Grants and select are registered; bus_out is combinational through the mux.
//
//   state   | meaning
//   --------+------------------------------------------------
//   ST_IDLE | no grant, sel holds its previous value
//   ST_G0   | requester 0 owns the port (gnt0=1, sel=0)
//   ST_G1   | requester 1 owns the port (gnt1=1, sel=1)
module bus_arbiter_2to1 #(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_valid
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_G0   = 2'b01,
    ST_G1   = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             grant_entry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
    end
  end

  // Next-state: a release hands over directly when the other side is waiting;
  // a forced switch only happens while the owner still requests.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1)  state_d = last_q ? ST_G0 : ST_G1;
        else if (req0)     state_d = ST_G0;
        else if (req1)     state_d = ST_G1;
      end
      ST_G0: begin
        if (!req0)                                state_d = req1 ? ST_G1 : ST_IDLE;
        else if (req1 && (hold_cnt_q == HOLD_MAX)) state_d = ST_G1;
      end
      ST_G1: begin
        if (!req1)                                state_d = req0 ? ST_G0 : ST_IDLE;
        else if (req0 && (hold_cnt_q == HOLD_MAX)) state_d = ST_G0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_entry = (state_d != state_q) && (state_d != ST_IDLE);
    hold_cnt_d  = hold_cnt_q;
    last_d      = last_q;
    sel_d       = sel_q;
    gnt0_d      = (state_d == ST_G0);
    gnt1_d      = (state_d == ST_G1);

    if (state_d == ST_IDLE) begin
      hold_cnt_d = '0;
    end else if (grant_entry) begin
      hold_cnt_d = CNT_W'(1);
      last_d     = (state_d == ST_G1);
    end else if (hold_cnt_q < HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end

    if (state_d == ST_G0)      sel_d = 1'b0;
    else if (state_d == ST_G1) sel_d = 1'b1;
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign sel       = sel_q;
  assign bus_valid = gnt0_q | gnt1_q;
  assign bus_out   = sel_q ? data1 : data0;

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Self-checking bench for bus_arbiter_2to1: directed scenarios plus randomized
// traffic compared against an owner/hold-count reference model.
module tb_bus_arbiter_2to1;

  localparam int W  = 32;
  localparam int MH = 4;

  logic         clk, reset, req0, req1;
  logic [W-1:0] data0, data1;
  logic         gnt0, gnt1, sel, bus_valid;
  logic [W-1:0] bus_out;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: current owner (-1 = none), cycles held, last winner, mux select.
  int m_owner, m_hold, m_last, m_sel;

  bus_arbiter_2to1 #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
    .sel(sel), .bus_out(bus_out), .bus_valid(bus_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, actual still running, required finished");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_owner = -1; m_hold = 0; m_last = 1; m_sel = 0;
  endfunction

  function automatic void model_edge(input logic r0, input logic r1);
    int nxt;
    logic mine, other;
    nxt = m_owner;
    if (m_owner < 0) begin
      if (r0 && r1) nxt = 1 - m_last;
      else if (r0)  nxt = 0;
      else if (r1)  nxt = 1;
    end else begin
      mine  = (m_owner == 0) ? r0 : r1;
      other = (m_owner == 0) ? r1 : r0;
      if (!mine)                       nxt = other ? 1 - m_owner : -1;
      else if (other && m_hold == MH)  nxt = 1 - m_owner;
    end
    if (nxt < 0)                m_hold = 0;
    else if (nxt != m_owner)    begin m_hold = 1; m_last = nxt; m_sel = nxt; end
    else if (m_hold < MH)       m_hold = m_hold + 1;
    m_owner = nxt;
  endfunction

  function automatic logic [W+3:0] exp_vec();
    return {logic'(m_owner == 0), logic'(m_owner == 1), logic'(m_sel == 1),
            logic'(m_owner >= 0), (m_sel == 1) ? data1 : data0};
  endfunction

  task automatic step();
    logic r0, r1;
    r0 = req0; r1 = req1;
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge(r0, r1);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = 35; data1 = $urandom;
    model_reset();
    repeat (2) step();
    n_cmp++;
    if ({gnt0, gnt1, sel, bus_valid, bus_out} !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_hold: actual %h required %h", {gnt0, gnt1, sel, bus_valid, bus_out}, exp_vec());
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if ({gnt0, gnt1, sel, bus_valid, bus_out} !== {4'b0000, 32'd35}) begin
      n_fail++;
      $display("FAIL reset_idle: actual %h required %h", {gnt0, gnt1, sel, bus_valid, bus_out}, {4'b0000, 32'd35});
    end
  endtask

  task automatic test_single();
    data1 = 32;
    req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if ({gnt0, gnt1, sel, bus_valid, bus_out} !== exp_vec() || gnt1 !== 1'b1 || bus_out !== 32'd32) begin
        n_fail++;
        $display("FAIL single_grant[%0d]: actual %h required %h", i, {gnt0, gnt1, sel, bus_valid, bus_out}, exp_vec());
      end
    end
    req1 = 1'b0;
    step();
    n_cmp++;
    if ({gnt0, gnt1, sel, bus_valid} !== 4'b0010) begin
      n_fail++;
      $display("FAIL single_release: actual gnt0/gnt1/sel/valid=%b required 0010", {gnt0, gnt1, sel, bus_valid});
    end
  endtask

  task automatic test_tie();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    step();
    reset = 1'b0;
    data0 = 35; data1 = 64;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      n_cmp++;
      if ({gnt0, gnt1, sel, bus_valid, bus_out} !== exp_vec()) begin
        n_fail++;
        $display("FAIL tie_model[%0d]: actual %h required %h", i, {gnt0, gnt1, sel, bus_valid, bus_out}, exp_vec());
      end
      if (i == 1 || i == 5 || i == 9) begin
        n_cmp++;
        if (bus_out !== ((i == 5) ? 32'd64 : 32'd35) || gnt1 !== (i == 5)) begin
          n_fail++;
          $display("FAIL tie_switch[%0d]: actual bus_out=%0d gnt1=%b required bus_out=%0d gnt1=%b",
                   i, bus_out, gnt1, (i == 5) ? 64 : 35, (i == 5));
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  task automatic test_handoff();
    req0 = 1'b1; req1 = 1'b0;
    step();
    req1 = 1'b1;
    step();
    req0 = 1'b0;
    step();
    n_cmp++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || bus_valid !== 1'b1 ||
        {gnt0, gnt1, sel, bus_valid, bus_out} !== exp_vec()) begin
      n_fail++;
      $display("FAIL handoff: actual %h required %h", {gnt0, gnt1, sel, bus_valid, bus_out}, exp_vec());
    end
  endtask

  task automatic test_mid_reset();
    req0 = 1'b0; req1 = 1'b1;
    step(); step();
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (gnt1 !== 1'b0 || sel !== 1'b0 || bus_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: actual gnt1=%b sel=%b valid=%b required 0 0 0", gnt1, sel, bus_valid);
    end
    step();
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    step();
    n_cmp++;
    if (gnt0 !== 1'b1 || {gnt0, gnt1, sel, bus_valid, bus_out} !== exp_vec()) begin
      n_fail++;
      $display("FAIL mid_reset_restart: actual %h required %h", {gnt0, gnt1, sel, bus_valid, bus_out}, exp_vec());
    end
  endtask

  task automatic test_fairness();
    int c0, c1;
    c0 = 0; c1 = 0;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      c0 += int'(gnt0); c1 += int'(gnt1);
      n_cmp++;
      if ((gnt0 & gnt1) !== 1'b0 || {gnt0, gnt1, sel, bus_valid, bus_out} !== exp_vec()) begin
        n_fail++;
        $display("FAIL fairness_cycle[%0d]: actual %h required %h", i, {gnt0, gnt1, sel, bus_valid, bus_out}, exp_vec());
      end
      req0 = ~gnt0; req1 = ~gnt1;
    end
    n_cmp++;
    if (c0 - c1 > 1 || c1 - c0 > 1 || c0 + c1 != 20) begin
      n_fail++;
      $display("FAIL fairness_count: actual g0=%0d g1=%0d required |diff|<=1 and total 20", c0, c1);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  task automatic test_random();
    int w0, w1;
    logic r0, r1;
    w0 = 0; w1 = 0;
    for (int i = 0; i < 300; i++) begin
      req0  = ($urandom_range(0, 3) != 0);
      req1  = ($urandom_range(0, 3) != 0);
      data0 = $urandom; data1 = $urandom;
      #1;
      n_cmp++;
      if (bus_out !== ((m_sel == 1) ? data1 : data0)) begin
        n_fail++;
        $display("FAIL rand_mux[%0d]: actual %h required %h", i, bus_out, (m_sel == 1) ? data1 : data0);
      end
      r0 = req0; r1 = req1;
      step();
      n_cmp++;
      if ({gnt0, gnt1, sel, bus_valid, bus_out} !== exp_vec()) begin
        n_fail++;
        $display("FAIL rand_model[%0d]: actual %h required %h", i, {gnt0, gnt1, sel, bus_valid, bus_out}, exp_vec());
      end
      w0 = (r0 && !gnt0) ? w0 + 1 : 0;
      w1 = (r1 && !gnt1) ? w1 + 1 : 0;
      n_cmp++;
      if (w0 > MH || w1 > MH) begin
        n_fail++;
        $display("FAIL rand_wait_bound[%0d]: actual waits %0d/%0d required <= %0d", i, w0, w1, MH);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    model_reset();
    test_reset();
    test_single();
    test_tie();
    test_handoff();
    test_mid_reset();
    test_fairness();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
